// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box table, GF(2^8) xtime, round count and FSM states.
// Used by aes_round_step and aes128_iter_core (optional AES_LAST_KEY_OUT_EN lives in the core).
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Entry 0x00 sits in the top byte so the table reads in natural order.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_step.sv
// One combinational AES round plus the matching on-the-fly key expansion step.
// `last` drops MixColumns for the final round.
module aes_round_step
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  input  logic         last,
  output logic [127:0] next_state,
  output logic [127:0] next_key,
  output logic [7:0]   next_rcon
);

  logic [31:0] w0, w1, w2, w3, tmp, nk0, nk1, nk2, nk3;
  assign {w0, w1, w2, w3} = key;
  // RotWord then SubWord, rcon folded into the leading byte
  assign tmp = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
  assign nk0 = w0 ^ tmp;
  assign nk1 = w1 ^ nk0;
  assign nk2 = w2 ^ nk1;
  assign nk3 = w3 ^ nk2;
  assign next_key  = {nk0, nk1, nk2, nk3};
  assign next_rcon = xtime(rcon);

  // [0] is the MSB byte, i.e. byte 0 of the column-major AES state
  logic [0:15][7:0] s_in, sb, sr, mc;
  assign s_in = state;

  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s_in[i]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
  end

  assign next_state = (last ? 128'(sr) : 128'(mc)) ^ next_key;

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor, RPC rounds per clock, keys expanded alongside the data.
// Define AES_LAST_KEY_OUT_EN to expose the round-10 key on out_key.
module aes128_iter_core
  import aes_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
`ifdef AES_LAST_KEY_OUT_EN
  ,
  output logic [127:0] out_key
`endif
);

  if (!(RPC == 1 || RPC == 2 || RPC == 5)) begin : g_bad_rpc
    $error("aes128_iter_core: RPC must be 1, 2 or 5");
  end

  state_t       state_q, state_d;
  logic [127:0] st_q, key_q, out_data_q;
  logic [7:0]   rcon_q;
  logic [3:0]   cnt_q;
  logic         fin;

  logic [RPC:0][127:0] st_c, key_c;
  logic [RPC:0][7:0]   rc_c;

  assign st_c[0]  = st_q;
  assign key_c[0] = key_q;
  assign rc_c[0]  = rcon_q;

  for (genvar j = 0; j < RPC; j++) begin : g_rnd
    aes_round_step u_step (
      .state      (st_c[j]),
      .key        (key_c[j]),
      .rcon       (rc_c[j]),
      .last       (cnt_q == 4'(NR - 1 - j)),
      .next_state (st_c[j+1]),
      .next_key   (key_c[j+1]),
      .next_rcon  (rc_c[j+1])
    );
  end

  assign fin = (cnt_q == 4'(NR - RPC));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (fin)       state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= '0;
      key_q      <= '0;
      rcon_q     <= 8'h01;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else if (state_q == IDLE && in_valid) begin
      st_q   <= in_data ^ in_key;
      key_q  <= in_key;
      rcon_q <= 8'h01;
      cnt_q  <= '0;
    end else if (state_q == RUN) begin
      st_q   <= st_c[RPC];
      key_q  <= key_c[RPC];
      rcon_q <= rc_c[RPC];
      cnt_q  <= cnt_q + 4'(RPC);
      if (fin) out_data_q <= st_c[RPC];
    end
  end

  assign out_data = out_data_q;

`ifdef AES_LAST_KEY_OUT_EN
  logic [127:0] out_key_q;
  always_ff @(posedge clk) begin
    if (rst)                     out_key_q <= '0;
    else if (state_q == RUN && fin) out_key_q <= key_c[RPC];
  end
  assign out_key = out_key_q;
`endif

endmodule

// File: tb/tb_aes128_iter_core.sv
// Directed scoreboard bench for aes128_iter_core (RPC=1 main instance, RPC=5 side instance).
module tb_aes128_iter_core;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] LK1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] LK2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, in_key, out_data, out_key;
  logic         r5_in_valid, r5_in_ready, r5_out_valid, r5_out_ready;
  logic [127:0] r5_in_data, r5_in_key, r5_out_data, r5_out_key;

  aes128_iter_core #(.RPC(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
`ifdef AES_LAST_KEY_OUT_EN
    , .out_key(out_key)
`endif
  );

  aes128_iter_core #(.RPC(5)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(r5_in_valid), .in_ready(r5_in_ready),
    .in_data(r5_in_data), .in_key(r5_in_key), .out_valid(r5_out_valid),
    .out_ready(r5_out_ready), .out_data(r5_out_data)
`ifdef AES_LAST_KEY_OUT_EN
    , .out_key(r5_out_key)
`endif
  );

`ifndef AES_LAST_KEY_OUT_EN
  assign out_key    = '0;
  assign r5_out_key = '0;
`endif

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] lk;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offers a block from the next falling edge; returns the acceptance cycle.
  task automatic send(input logic [127:0] d, input logic [127:0] k,
                      input logic [127:0] ct, input logic [127:0] lk, output int acc);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("send_in_ready", 128'(in_ready), 128'(1));
    in_valid = 1'b1; in_data = d; in_key = k;
    sbq.push_back('{ct, lk});
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  // Waits for out_valid; exp_lat counts edges from the first falling edge inspected.
  task automatic collect(input int exp_lat, input string tag);
    int lat = 0;
    exp_t e;
    @(negedge clk);
    while (!out_valid && lat < 200) begin lat++; @(negedge clk); end
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_sb_nonempty"}, 128'(sbq.size() != 0), 128'(1));
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk({tag, "_ct"}, out_data, e.ct);
`ifdef AES_LAST_KEY_OUT_EN
      chk({tag, "_lastkey"}, out_key, e.lk);
`endif
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle_in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_idle_out_valid"}, 128'(out_valid), 128'(0));
  endtask

  task automatic quiet(input int n, input string tag);
    logic seen = 1'b0;
    repeat (n) begin @(negedge clk); seen |= out_valid; end
    chk({tag, "_no_out_valid"}, 128'(seen), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int a0, a1, lat;
    logic hold_ok;
    exp_t e;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
    r5_in_valid = 1'b0; r5_out_ready = 1'b1; r5_in_data = '0; r5_in_key = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_data", out_data, '0);
`ifdef AES_LAST_KEY_OUT_EN
    chk("reset_out_key", out_key, '0);
`endif

    // basic FIPS-197 vectors
    send(P1, K1, C1, LK1, a0);
    collect(10, "v1");
    release_out("v1");

    // backpressure: result held for 20 cycles
    send(P2, K2, C2, LK2, a0);
    collect(10, "v2");
    hold_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && out_data === C2 && in_ready === 1'b0)) hold_ok = 1'b0;
    end
    chk("hold_stable", 128'(hold_ok), 128'(1));
    release_out("hold");

    // input churn during RUN must not disturb the block in flight
    send(P1, K1, C1, LK1, a0);
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_key   = {$urandom, $urandom, $urandom, $urandom};
    end
    in_valid = 1'b0;
    collect(10 - 4, "churn");
    release_out("churn");
    quiet(15, "churn");

    // reset at round 5 discards the block
    send(P2, K2, C2, LK2, a0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sbq.pop_back());
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_data", out_data, '0);
    quiet(15, "midrst");
    send(P1, K1, C1, LK1, a0);
    collect(10, "after_rst");
    release_out("after_rst");

    // reset beats a simultaneous in_valid
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = P2; in_key = K2;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_vs_valid_in_ready", 128'(in_ready), 128'(1));
    quiet(15, "rst_vs_valid");

    // back-to-back with out_ready tied high
    out_ready = 1'b1;
    send(P1, K1, C1, LK1, a0);
    collect(10, "b2b_a");
    send(P2, K2, C2, LK2, a1);
    chk("b2b_interval", 128'(a1 - a0), 128'(12));
    collect(10, "b2b_b");
    @(negedge clk);
    chk("b2b_idle", 128'(in_ready), 128'(1));
    out_ready = 1'b0;

    // RPC=5 instance: two edges of latency
    @(negedge clk);
    chk("r5_in_ready", 128'(r5_in_ready), 128'(1));
    r5_in_valid = 1'b1; r5_in_data = P2; r5_in_key = K2;
    sbq.push_back('{C2, LK2});
    @(posedge clk); #1;
    r5_in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!r5_out_valid && lat < 50) begin lat++; @(negedge clk); end
    chk("r5_latency", 128'(lat), 128'(2));
    e = sbq.pop_front();
    chk("r5_ct", r5_out_data, e.ct);
`ifdef AES_LAST_KEY_OUT_EN
    chk("r5_lastkey", r5_out_key, e.lk);
`endif
    @(negedge clk);
    chk("r5_idle", 128'(r5_in_ready), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/aes128_iter_core.md
# aes128_iter_core

Iterative AES-128 encryption core: accepts a 128-bit plaintext and key over a valid/ready handshake, runs the initial AddRoundKey, nine full rounds and the final round (SubBytes, ShiftRows, AddRoundKey, no MixColumns) on a registered state, and returns the ciphertext over a valid/ready handshake. Round keys are expanded on the fly alongside the data path, so no key storage is needed. `RPC` trades area for latency by unrolling rounds per clock. The core is the sequential successor to the existing single-round combinational blocks and sits between the host interface and the ciphertext sink.

## Interface
- `RPC`, default 1: rounds computed per clock; legal values 1, 2, 5 (must divide 10). Other values are an elaboration error.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_data`/`in_key` hold a block.
- `in_ready` output 1: core can accept; high only in IDLE.
- `in_data` input 128: plaintext; bit 127 is FIPS-197 byte 0.
- `in_key` input 128: cipher key, same byte order.
- `out_valid` output 1: `out_data` holds a ciphertext.
- `out_ready` input 1: sink accepts ciphertext.
- `out_data` output 128: ciphertext.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready` → state reg ← `in_data`^`in_key`, key reg ← `in_key`, rcon reg ← 0x01, round cnt ← 0, go RUN.
- RUN: each edge applies `RPC` rounds in sequence. For each round: next key = key expansion(key, rcon), rcon ← xtime(rcon) (0x80→0x1b, 0x1b→0x36), round cnt += 1. Rounds 1–9 are full rounds; round 10 skips MixColumns. When round cnt reaches 10, `out_data` ← state, go DONE.
- DONE: `out_valid`=1; `out_data` stable until accepted. On `out_ready` → IDLE. `out_ready` without `out_valid` has no effect.
- Inputs are sampled only on the acceptance edge; later changes to `in_data`/`in_key` do not affect the block in flight.
- `in_valid` outside IDLE is ignored (no buffering, no error).
- All arithmetic is GF(2^8) with polynomial 0x11b; round cnt is 4 bits and never exceeds 10.

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `out_data`=0, state/key regs 0, rcon 0x01, round cnt 0.
- Latency: `out_valid` rises 10/`RPC` edges after the acceptance edge (10, 5 or 2).
- Throughput: one block per 10/`RPC`+2 cycles with `out_ready` tied high.
- `in_ready` is a registered-state decode: no combinational path from `in_valid` or `out_ready`.
- `rst` mid-RUN or in DONE: the block is discarded, all regs return to reset values on that edge, and no `out_valid` pulse follows.
- If `rst` and `in_valid` are high on the same edge, reset wins and the block is not accepted.

## Configuration
- `AES_LAST_KEY_OUT_EN` defined: adds output port `out_key` (128 bits), which carries the round-10 key. It is valid and stable exactly when `out_valid`=1, resets to 0, and is used to seed a decryption key schedule.
- Not defined: the port is absent and the last key is not registered separately.

## Structure
- Shared package `aes_pkg`: S-box constant table, `xtime` function, round count constant NR=10, FSM state enum.
- One sub-module `aes_round_step`: a combinational single round taking state, key and rcon, with a `last` input that bypasses MixColumns. It returns the next state, next key and next rcon. The core instantiates `RPC` copies of it in a chain.

## Test plan
- Key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff → `out_data` 69c4e0d86a7b0430d8cdb78070b4c55a, with `out_valid` exactly 10/`RPC` edges after acceptance. Run for `RPC`=1, 2 and 5.
- Key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32. With `AES_LAST_KEY_OUT_EN` defined, `out_key` = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Hold `out_ready`=0 for 20 cycles after DONE → `out_valid` stays 1, `out_data` stable and `in_ready` 0. Raising `out_ready` returns the core to IDLE on the next edge.
- Change `in_data` and toggle `in_valid` during RUN → the result still matches the originally accepted vector and the second block is not accepted.
- Assert `rst` at round 5 of a block → regs go to reset values, no `out_valid` follows, and the next block then encrypts correctly.
- Back-to-back blocks with `out_ready`=1 → `in_ready` returns 10/`RPC`+2 cycles after each acceptance and both ciphertexts are correct.
